// File: rtl/mips_fetch_buffer.sv
// Instruction fetch stage for the multicycle MIPS core: issues word-addressed
// fetches to instruction memory and feeds the core from a small prefetch queue.
module mips_fetch_buffer #(
   parameter int unsigned       DEPTH    = 2,
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    redirect,
   input  logic [ADDR_W-1:0]       redirect_pc,
   output logic                    imem_req,
   output logic [ADDR_W-1:0]       imem_addr,
   input  logic                    imem_ack,
   input  logic [31:0]             imem_rdata,
   output logic                    inst_valid,
   output logic [ADDR_W-1:0]       inst_pc,
   output logic [31:0]             inst_data,
   input  logic                    inst_ready,
   output logic [$clog2(DEPTH):0]  count,
   output logic [1:0]              state_dbg
);

   // Handshakes: memory transfers on imem_req & imem_ack, with imem_addr held
   // while imem_req waits; the core consumes the head on inst_valid & inst_ready.

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d, count_nxt;
   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [31:0]       data_mem [DEPTH];
   logic              push, pop, has_room;

   assign has_room  = count_q < FULL;
   assign push      = (state_q == S_REQ) && imem_ack && !redirect;
   assign pop       = (count_q != '0) && inst_ready;
   assign count_nxt = count_q + CW'(push) - CW'(pop);

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (!redirect && has_room) state_d = S_REQ;
         S_REQ: begin
            if (redirect)                               state_d = imem_ack ? S_IDLE : S_DROP;
            else if (imem_ack && (count_nxt == FULL))   state_d = S_IDLE;
         end
         S_DROP: if (imem_ack) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req  = (state_q != S_IDLE);
      state_dbg = state_q;
   end

   // A redirect flushes the queue and wins over any same-cycle push or pop.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (redirect)  fetch_pc_d = redirect_pc;
      else if (push) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      if ((state_q == S_IDLE) && !redirect && has_room) addr_d = fetch_pc_q;
      else if (push)                                     addr_d = fetch_pc_q + ADDR_W'(1);
      if (redirect) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         pc_mem[wr_ptr_q]   <= fetch_pc_q;
         data_mem[wr_ptr_q] <= imem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) assert (!(push && (count_q == FULL)));
   end

   assign imem_addr  = addr_q;
   assign inst_valid = (count_q != '0);
   assign inst_pc    = pc_mem[rd_ptr_q];
   assign inst_data  = data_mem[rd_ptr_q];
   assign count      = count_q;

endmodule

// File: tb/tb_mips_fetch_buffer.sv
// Directed bench for mips_fetch_buffer: inputs change and outputs are sampled
// on the falling edge; memory returns 0x1000_0000 + address unless forced.
module tb_mips_fetch_buffer;

   localparam int unsigned DEPTH  = 2;
   localparam int unsigned ADDR_W = 32;
   localparam logic [1:0]  ST_IDLE = 2'd0;
   localparam logic [1:0]  ST_REQ  = 2'd1;
   localparam logic [1:0]  ST_DROP = 2'd2;

   logic              clk = 1'b0;
   logic              rst;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;
   logic              inst_valid;
   logic [ADDR_W-1:0] inst_pc;
   logic [31:0]       inst_data;
   logic              inst_ready;
   logic [1:0]        count;
   logic [1:0]        state_dbg;

   logic              force_en;
   logic [31:0]       force_val;
   logic              saw_dead;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign imem_rdata = force_en ? force_val : (32'h1000_0000 + imem_addr);

   mips_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC('0)) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_pc     (inst_pc),
      .inst_data   (inst_data),
      .inst_ready  (inst_ready),
      .count       (count),
      .state_dbg   (state_dbg)
   );

   always @(negedge clk) begin
      if (inst_valid && inst_data == 32'h0000_DEAD) saw_dead = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0;
      inst_ready = 1'b0; force_en = 1'b0; force_val = '0; saw_dead = 1'b0;
      tick(); tick();

      // Reset state
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_count", {30'b0, count}, 32'd0);
      check("rst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst_state", {30'b0, state_dbg}, {30'b0, ST_IDLE});

      // Streaming with zero-wait memory and an always-ready core
      rst = 1'b0; imem_ack = 1'b1; inst_ready = 1'b1;
      tick();
      check("s_req", {31'b0, imem_req}, 32'd1);
      check("s_addr0", imem_addr, 32'd0);
      check("s_valid0", {31'b0, inst_valid}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("s_addr", imem_addr, i + 1);
         check("s_pc", inst_pc, i);
         check("s_data", inst_data, 32'h1000_0000 + i);
         check("s_count", {30'b0, count}, 32'd1);
      end

      // Back-pressure: fill, stall, single pop, refill
      do_reset();
      imem_ack = 1'b1; inst_ready = 1'b0;
      tick(); tick(); tick();
      check("bp_count2", {30'b0, count}, 32'd2);
      check("bp_req0", {31'b0, imem_req}, 32'd0);
      check("bp_head0", inst_pc, 32'd0);
      tick();
      check("bp_hold_req", {31'b0, imem_req}, 32'd0);
      check("bp_hold_pc", inst_pc, 32'd0);
      check("bp_hold_data", inst_data, 32'h1000_0000);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      check("bp_count1", {30'b0, count}, 32'd1);
      check("bp_head1", inst_pc, 32'd1);
      tick();
      check("bp_req1", {31'b0, imem_req}, 32'd1);
      check("bp_addr2", imem_addr, 32'd2);
      tick();
      check("bp_refill", {30'b0, count}, 32'd2);
      check("bp_head1b", inst_pc, 32'd1);
      check("bp_idle", {30'b0, state_dbg}, {30'b0, ST_IDLE});

      // Redirect from IDLE with pcs 4,5 queued; pop on the same cycle is overridden
      do_reset();
      imem_ack = 1'b1; inst_ready = 1'b0;
      redirect = 1'b1; redirect_pc = 32'd4;
      tick();
      redirect = 1'b0;
      tick(); tick(); tick();
      check("ri_count2", {30'b0, count}, 32'd2);
      check("ri_head4", inst_pc, 32'd4);
      check("ri_idle", {30'b0, state_dbg}, {30'b0, ST_IDLE});
      redirect = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b1;
      tick();
      redirect = 1'b0; inst_ready = 1'b0;
      check("ri_flush_cnt", {30'b0, count}, 32'd0);
      check("ri_flush_vld", {31'b0, inst_valid}, 32'd0);
      tick();
      check("ri_addr40", imem_addr, 32'h40);
      check("ri_req", {31'b0, imem_req}, 32'd1);

      // Redirect while a request is outstanding: stale response is dropped
      do_reset();
      imem_ack = 1'b0; inst_ready = 1'b1;
      redirect = 1'b1; redirect_pc = 32'd7;
      tick();
      redirect = 1'b0;
      tick();
      check("dr_addr7", imem_addr, 32'd7);
      redirect = 1'b1; redirect_pc = 32'h20;
      tick();
      redirect = 1'b0;
      check("dr_state", {30'b0, state_dbg}, {30'b0, ST_DROP});
      check("dr_req", {31'b0, imem_req}, 32'd1);
      check("dr_hold_a", imem_addr, 32'd7);
      tick();
      tick();
      check("dr_hold_b", imem_addr, 32'd7);
      check("dr_valid", {31'b0, inst_valid}, 32'd0);
      imem_ack = 1'b1; force_en = 1'b1; force_val = 32'h0000_DEAD;
      tick();
      imem_ack = 1'b0; force_en = 1'b0;
      check("dr_idle", {30'b0, state_dbg}, {30'b0, ST_IDLE});
      check("dr_count", {30'b0, count}, 32'd0);
      tick();
      check("dr_addr20", imem_addr, 32'h20);
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      check("dr_pc20", inst_pc, 32'h20);
      check("dr_data20", inst_data, 32'h1000_0020);

      // Redirect on the same cycle as the ack for address 3
      do_reset();
      imem_ack = 1'b0; inst_ready = 1'b1;
      redirect = 1'b1; redirect_pc = 32'd3;
      tick();
      redirect = 1'b0;
      tick();
      check("ra_addr3", imem_addr, 32'd3);
      imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h10;
      tick();
      redirect = 1'b0;
      check("ra_idle", {30'b0, state_dbg}, {30'b0, ST_IDLE});
      check("ra_count", {30'b0, count}, 32'd0);
      check("ra_valid", {31'b0, inst_valid}, 32'd0);
      tick();
      check("ra_addr10", imem_addr, 32'h10);

      // PC wraps modulo 2^ADDR_W
      do_reset();
      imem_ack = 1'b1; inst_ready = 1'b1;
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      tick();
      redirect = 1'b0;
      tick(); tick();
      check("wr_pc", inst_pc, 32'hFFFF_FFFF);
      check("wr_addr", imem_addr, 32'd0);

      // Reset while a request is pending with the queue partly full
      do_reset();
      imem_ack = 1'b1; inst_ready = 1'b0;
      tick(); tick(); tick();
      imem_ack = 1'b0; inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      tick();
      check("rr_req", {31'b0, imem_req}, 32'd1);
      check("rr_addr2", imem_addr, 32'd2);
      check("rr_count1", {30'b0, count}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0; imem_ack = 1'b1;
      check("rr_req0", {31'b0, imem_req}, 32'd0);
      check("rr_count0", {30'b0, count}, 32'd0);
      check("rr_state", {30'b0, state_dbg}, {30'b0, ST_IDLE});
      tick();
      check("rr_restart", imem_addr, 32'd0);
      check("rr_req1", {31'b0, imem_req}, 32'd1);

      tick();
      check("no_dead", {31'b0, saw_dead}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
